// File: rtl/mmu_dispatch_ctrl.sv
// mmu_dispatch_ctrl
// Queues translation requests in a small FIFO and issues them one at a time
// to a downstream 2-way selector. Each issue is a single-cycle drive pulse.
// The selector's completion pulse then retires the head entry.
//
// Ports
//   clk       : sole clock, rising edge
//   rst       : asynchronous active-high reset
//   i_valid   : upstream request present (push = i_valid & o_ready)
//   o_ready   : FIFO has room
//   i_vaddr   : request virtual address
//   i_route   : destination, 0 -> port0, 1 -> port1
//   o_drive   : one-cycle issue pulse to the selector
//   o_select  : one-hot destination (01 port0, 10 port1, 00 idle)
//   o_vaddr   : address of the in-flight request (holds in idle)
//   i_free    : one-cycle completion pulse from the selector
//   o_count   : FIFO occupancy
//   o_err     : sticky flag, set by a completion pulse with nothing waiting
module mmu_dispatch_ctrl #(
  parameter int VA_W  = 32,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [VA_W-1:0] i_vaddr,
  input  logic            i_route,
  output logic            o_drive,
  output logic [1:0]      o_select,
  output logic [VA_W-1:0] o_vaddr,
  input  logic            i_free,
  output logic [CW-1:0]   o_count,
  output logic            o_err
);

  typedef enum logic [1:0] {IDLE, DRIVE, WAIT} state_t;

  // Entry layout: {route, vaddr}
  logic [VA_W:0] mem [DEPTH];

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            drive_q, drive_d;
  logic [1:0]      select_q, select_d;
  logic [VA_W-1:0] vaddr_q, vaddr_d;
  logic            err_q, err_d;

  logic          push, pop;
  logic [VA_W:0] head_cur, head_next;

  always_comb begin
    push = i_valid && (count_q != CW'(DEPTH));
    pop  = (state_q == WAIT) && i_free;

    // An empty FIFO takes its head from the incoming request in the same
    // edge, so a push into an empty queue is issued one cycle later.
    head_cur  = (count_q != '0) ? mem[rd_ptr_q] : {i_route, i_vaddr};
    // Head after a pop: the next stored entry, or a same-cycle push.
    head_next = (count_q > CW'(1)) ? mem[rd_ptr_q + PW'(1)] : {i_route, i_vaddr};

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);

    state_d  = state_q;
    drive_d  = 1'b0;
    select_d = select_q;
    vaddr_d  = vaddr_q;
    err_d    = err_q || (i_free && (state_q != WAIT));

    unique case (state_q)
      IDLE: begin
        select_d = 2'b00;
        if ((count_q != '0) || push) begin
          state_d  = DRIVE;
          drive_d  = 1'b1;
          select_d = head_cur[VA_W] ? 2'b10 : 2'b01;
          vaddr_d  = head_cur[VA_W-1:0];
        end
      end
      DRIVE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (i_free) begin
          if ((count_q > CW'(1)) || push) begin
            state_d  = DRIVE;
            drive_d  = 1'b1;
            select_d = head_next[VA_W] ? 2'b10 : 2'b01;
            vaddr_d  = head_next[VA_W-1:0];
          end else begin
            state_d  = IDLE;
            select_d = 2'b00;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        select_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drive_q  <= 1'b0;
      select_q <= 2'b00;
      vaddr_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drive_q  <= drive_d;
      select_q <= select_d;
      vaddr_q  <= vaddr_d;
      err_q    <= err_d;
    end
  end

  // Storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {i_route, i_vaddr};
  end

  assign o_ready  = (count_q != CW'(DEPTH));
  assign o_drive  = drive_q;
  assign o_select = select_q;
  assign o_vaddr  = vaddr_q;
  assign o_count  = count_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_mmu_dispatch_ctrl.sv
module tb_mmu_dispatch_ctrl;
  localparam int VA_W = 32;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic            clk, rst, i_valid, o_ready, i_route, o_drive, i_free, o_err;
  logic [VA_W-1:0] i_vaddr, o_vaddr;
  logic [1:0]      o_select;
  logic [CW-1:0]   o_count;

  mmu_dispatch_ctrl #(.VA_W(VA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_vaddr(i_vaddr), .i_route(i_route), .o_drive(o_drive),
    .o_select(o_select), .o_vaddr(o_vaddr), .i_free(i_free),
    .o_count(o_count), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic route; logic [VA_W-1:0] va; } req_t;
  req_t sb[$];
  req_t cur;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_drv = 0;
  int   drv_cyc[$];
  bit   drive_pending = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one cycle; sample 1 ns after the edge and score any issue.
  task automatic tick();
    req_t e;
    @(posedge clk); #1;
    cyc++;
    if (o_drive) begin
      drive_pending = 1;
      last_drv = cyc;
      drv_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check_val("drive_unexpected", 64'(o_drive), 64'd0);
      end else begin
        e = sb.pop_front();
        cur = e;
        check_val("drive_select", 64'(o_select), e.route ? 64'd2 : 64'd1);
        check_val("drive_vaddr", 64'(o_vaddr), 64'(e.va));
        $display("issue cyc=%0d route=%0d vaddr=%08h", cyc, e.route, e.va);
      end
    end
  endtask

  task automatic push_req(input logic route, input logic [VA_W-1:0] va, input bit accept);
    i_valid = 1'b1; i_route = route; i_vaddr = va;
    if (accept) sb.push_back('{route: route, va: va});
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_drive(input string tag);
    int n = 0;
    while (!drive_pending && n < 20) begin tick(); n++; end
    if (!drive_pending) check_val(tag, 64'd0, 64'd1);
    drive_pending = 0;
  endtask

  // Complete the in-flight request with i_free asserted gap cycles after its drive.
  task automatic serve(input int gap);
    wait_drive("drive_timeout");
    while (cyc < last_drv + gap) tick();
    check_val("hold_select", 64'(o_select), cur.route ? 64'd2 : 64'd1);
    check_val("hold_vaddr", 64'(o_vaddr), 64'(cur.va));
    i_free = 1'b1;
    tick();
    i_free = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_route = 1'b0; i_vaddr = '0; i_free = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_count", 64'(o_count), 64'd0);
    check_val("rst_drive", 64'(o_drive), 64'd0);
    check_val("rst_select", 64'(o_select), 64'd0);
    check_val("rst_vaddr", 64'(o_vaddr), 64'd0);
    check_val("rst_err", 64'(o_err), 64'd0);
    rst = 1'b0;
    check_val("rel_ready", 64'(o_ready), 64'd1);
    tick();
    check_val("idle_drive", 64'(o_drive), 64'd0);

    // Single request: push at edge 0, drive in cycle 1, free in cycle 4.
    push_req(1'b1, 32'h0000_1000, 1);
    check_val("single_drive", 64'(o_drive), 64'd1);
    drive_pending = 0;
    tick(); tick();
    check_val("single_wait_drive", 64'(o_drive), 64'd0);
    tick();
    check_val("single_wait_sel", 64'(o_select), 64'd2);
    i_free = 1'b1;
    tick();
    i_free = 1'b0;
    check_val("single_done_count", 64'(o_count), 64'd0);
    check_val("single_done_sel", 64'(o_select), 64'd0);
    check_val("single_done_vaddr", 64'(o_vaddr), 64'h1000);

    // Fill to DEPTH with no completions, then try one more.
    for (int i = 0; i < DEPTH; i++) push_req(i[0], 32'h2000 + 32'(i * 16), 1);
    check_val("fill_count", 64'(o_count), 64'(DEPTH));
    check_val("fill_ready", 64'(o_ready), 64'd0);
    push_req(1'b1, 32'hDEAD_0000, 0);
    check_val("fill_reject_count", 64'(o_count), 64'(DEPTH));
    serve(1);
    check_val("fill_ready_again", 64'(o_ready), 64'd1);
    check_val("fill_count_dec", 64'(o_count), 64'(DEPTH - 1));
    for (int i = 0; i < DEPTH - 1; i++) serve(2);
    check_val("fill_drained", 64'(o_count), 64'd0);

    // Back-to-back issue, routes 0,1,0, free two cycles after each drive.
    drv_cyc.delete();
    push_req(1'b0, 32'h3000, 1);
    push_req(1'b1, 32'h3004, 1);
    push_req(1'b0, 32'h3008, 1);
    for (int i = 0; i < 3; i++) serve(2);
    check_val("b2b_drives", 64'(drv_cyc.size()), 64'd3);
    if (drv_cyc.size() == 3) begin
      check_val("b2b_gap1", 64'(drv_cyc[1] - drv_cyc[0]), 64'd3);
      check_val("b2b_gap2", 64'(drv_cyc[2] - drv_cyc[1]), 64'd3);
    end

    // Wrap-around: ten push/complete pairs through the pointers.
    for (int i = 0; i < 10; i++) begin
      push_req(1'($urandom_range(0, 1)), $urandom, 1);
      check_val("wrap_count_one", 64'(o_count), 64'd1);
      serve(1);
      check_val("wrap_count_zero", 64'(o_count), 64'd0);
    end

    // Completion pulse with nothing outstanding.
    i_free = 1'b1;
    tick();
    i_free = 1'b0;
    check_val("spur_err", 64'(o_err), 64'd1);
    check_val("spur_count", 64'(o_count), 64'd0);
    check_val("spur_select", 64'(o_select), 64'd0);
    repeat (3) tick();
    check_val("spur_err_sticky", 64'(o_err), 64'd1);
    check_val("spur_no_drive", 64'(drive_pending), 64'd0);

    // Reset while waiting with two more queued.
    push_req(1'b1, 32'h4000, 1);
    push_req(1'b0, 32'h4004, 1);
    push_req(1'b1, 32'h4008, 1);
    tick();
    check_val("prerst_count", 64'(o_count), 64'd3);
    #2 rst = 1'b1;
    #1;
    check_val("arst_count", 64'(o_count), 64'd0);
    check_val("arst_drive", 64'(o_drive), 64'd0);
    check_val("arst_select", 64'(o_select), 64'd0);
    check_val("arst_err", 64'(o_err), 64'd0);
    sb.delete();
    drive_pending = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) tick();
    check_val("post_rst_no_drive", 64'(drive_pending), 64'd0);
    check_val("post_rst_count", 64'(o_count), 64'd0);
    i_free = 1'b1;
    tick();
    i_free = 1'b0;
    check_val("post_rst_late_free", 64'(o_err), 64'd1);
    push_req(1'b0, 32'h5000, 1);
    serve(1);
    check_val("final_count", 64'(o_count), 64'd0);
    check_val("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
